// File: rtl/pwm_level_driver.sv
// Level-to-PWM converter: LEVEL is latched into a shadow duty register only at period
// boundaries, so the output never glitches. Optional gamma ROM: define PWM_GAMMA_EN.
module pwm_level_driver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PRESCALE    = 256,
    parameter int unsigned ACTIVE_HIGH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] LEVEL,
    output logic             PWM_OUT,
    output logic [WIDTH-1:0] DUTY_Q,
    output logic             PERIOD_STB
);

    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;
    localparam logic             INACTIVE = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

`ifdef PWM_GAMMA_EN
    generate
        if (WIDTH != 4) begin : g_bad_width
            $error("pwm_level_driver: PWM_GAMMA_EN requires WIDTH=4");
        end
    endgenerate
`endif

    // Level-to-duty mapping; purely combinational so it adds no latency.
    function automatic logic [WIDTH-1:0] map_level(input logic [WIDTH-1:0] lvl);
`ifdef PWM_GAMMA_EN
        logic [3:0] g;
        case (4'(lvl))
            4'd0:    g = 4'd0;
            4'd1:    g = 4'd0;
            4'd2:    g = 4'd0;
            4'd3:    g = 4'd1;
            4'd4:    g = 4'd1;
            4'd5:    g = 4'd1;
            4'd6:    g = 4'd2;
            4'd7:    g = 4'd2;
            4'd8:    g = 4'd3;
            4'd9:    g = 4'd4;
            4'd10:   g = 4'd5;
            4'd11:   g = 4'd6;
            4'd12:   g = 4'd8;
            4'd13:   g = 4'd10;
            4'd14:   g = 4'd12;
            default: g = 4'd15;
        endcase
        return WIDTH'(g);
`else
        return lvl;
`endif
    endfunction

    logic [PRE_W-1:0] pre_q,  pre_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             stb_q,  stb_d;
    logic             out_q,  out_d;
    logic             step_tick_c;
    logic             boundary_c;

    assign step_tick_c = EN && (pre_q == PRE_LAST);
    assign boundary_c  = step_tick_c && (cnt_q == CNT_LAST);

    // Next-state: EN low parks the counters and tracks LEVEL so a restart begins a clean period.
    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        duty_d = duty_q;
        stb_d  = 1'b0;
        out_d  = INACTIVE;
        if (!EN) begin
            pre_d  = '0;
            cnt_d  = '0;
            duty_d = map_level(LEVEL);
        end else begin
            pre_d  = step_tick_c ? '0 : pre_q + PRE_W'(1);
            cnt_d  = step_tick_c ? cnt_q + WIDTH'(1) : cnt_q;
            duty_d = boundary_c ? map_level(LEVEL) : duty_q;
            stb_d  = boundary_c;
            out_d  = (cnt_q < duty_q) ^ INACTIVE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
            stb_q  <= 1'b0;
            out_q  <= INACTIVE;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            stb_q  <= stb_d;
            out_q  <= out_d;
        end
    end

    assign PWM_OUT    = out_q;
    assign DUTY_Q     = duty_q;
    assign PERIOD_STB = stb_q;

endmodule

// File: tb/tb_pwm_level_driver.sv
// Directed bench for pwm_level_driver (PRESCALE=2, WIDTH=4): an active-high and an
// inverted instance share inputs; expected values are hand-derived per step.
module tb_pwm_level_driver;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] LEVEL;
    logic       pwm_h, stb_h, pwm_l, stb_l;
    logic [3:0] duty_h, duty_l;
    bit         clk_run;

    int vectors;
    int miscompares;

    pwm_level_driver #(.WIDTH(4), .PRESCALE(2), .ACTIVE_HIGH(1)) dut_h (
        .CLK(CLK), .RST(RST), .EN(EN), .LEVEL(LEVEL),
        .PWM_OUT(pwm_h), .DUTY_Q(duty_h), .PERIOD_STB(stb_h)
    );

    pwm_level_driver #(.WIDTH(4), .PRESCALE(2), .ACTIVE_HIGH(0)) dut_l (
        .CLK(CLK), .RST(RST), .EN(EN), .LEVEL(LEVEL),
        .PWM_OUT(pwm_l), .DUTY_Q(duty_l), .PERIOD_STB(stb_l)
    );

    // Gateable clock so reset can be exercised with the clock stopped low.
    always begin
        #5;
        if (clk_run) CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int map_lvl(input int l);
`ifdef PWM_GAMMA_EN
        int tbl [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
        return tbl[l];
`else
        return l;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance until PERIOD_STB is seen (bounded), counting on-cycles of both instances.
    task automatic wait_stb(input int limit, output int n, output int highs, output int lows);
        n = 0; highs = 0; lows = 0;
        do begin
            tick();
            n++;
            highs += int'(pwm_h);
            lows  += int'(!pwm_l);
        end while (!stb_h && n < limit);
    endtask

    // From a strobe cycle, sample one whole period and step onto the next strobe cycle.
    task automatic measure(input int chg_at, input logic [3:0] chg_lvl,
                           output int highs, output int lows, output int stb_mid,
                           output int duty_last, output int stb_next);
        highs = int'(pwm_h); lows = int'(!pwm_l); stb_mid = 0;
        for (int i = 1; i < 32; i++) begin
            if (i == chg_at) LEVEL = chg_lvl;
            tick();
            highs   += int'(pwm_h);
            lows    += int'(!pwm_l);
            stb_mid += int'(stb_h) + int'(stb_l);
        end
        duty_last = int'(duty_h);
        tick();
        stb_next = int'(stb_h);
    endtask

    initial begin
        int n, hi, lo, sm, dl, sn;
        vectors = 0; miscompares = 0;
        clk_run = 1'b1;
        RST = 1'b1; EN = 1'b1; LEVEL = 4'd5;

        // Reset state
        #2 RST = 1'b0;
        #1;
        check("rst_pwm_h", int'(pwm_h), 0);
        check("rst_pwm_l", int'(pwm_l), 1);
        check("rst_duty", int'(duty_h), 0);
        check("rst_stb", int'(stb_h), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // First period after reset is all off; strobe lands 32 cycles in
        wait_stb(64, n, hi, lo);
        check("first_stb_cycles", n, 32);
        check("first_period_high", hi, 0);
        check("first_period_low_inv", lo, 0);
        check("duty_after_stb", int'(duty_h), map_lvl(5));
        check("duty_inv_after_stb", int'(duty_l), map_lvl(5));
        measure(-1, 4'd0, hi, lo, sm, dl, sn);
        check("lvl5_high", hi, 2 * map_lvl(5));
        check("lvl5_inv_low", lo, 2 * map_lvl(5));
        check("lvl5_no_mid_stb", sm, 0);
        check("lvl5_next_stb", sn, 1);
        measure(-1, 4'd0, hi, lo, sm, dl, sn);
        check("lvl5_high_p2", hi, 2 * map_lvl(5));
        check("lvl5_next_stb_p2", sn, 1);

        // Asynchronous reset mid-period with the clock stopped
        tick(); tick();
        check("mid_on_h", int'(pwm_h), 1);
        check("mid_on_l", int'(pwm_l), 0);
        @(negedge CLK);
        clk_run = 1'b0;
        #20 RST = 1'b0;
        #1;
        check("async_rst_pwm_h", int'(pwm_h), 0);
        check("async_rst_pwm_l", int'(pwm_l), 1);
        check("async_rst_duty", int'(duty_h), 0);
        check("async_rst_stb", int'(stb_h), 0);
        LEVEL = 4'd0;
        #7;
        RST = 1'b1;
        clk_run = 1'b1;

        // LEVEL=0 never on, then LEVEL=15 on 30 of 32
        wait_stb(64, n, hi, lo);
        check("restart_stb_cycles", n, 32);
        check("lvl0_duty", int'(duty_h), 0);
        LEVEL = 4'd15;
        measure(-1, 4'd0, hi, lo, sm, dl, sn);
        check("lvl0_high", hi, 0);
        check("lvl0_inv_low", lo, 0);
        check("lvl15_duty", int'(duty_h), map_lvl(15));
        LEVEL = 4'd3;
        measure(-1, 4'd0, hi, lo, sm, dl, sn);
        check("lvl15_high", hi, 2 * map_lvl(15));
        check("lvl15_inv_low", lo, 2 * map_lvl(15));

        // Mid-period LEVEL change is held off until the boundary
        check("lvl3_duty", int'(duty_h), map_lvl(3));
        measure(16, 4'd12, hi, lo, sm, dl, sn);
        check("lvl3_high", hi, 2 * map_lvl(3));
        check("lvl3_duty_held", dl, map_lvl(3));
        check("lvl3_next_stb", sn, 1);
        check("lvl12_duty", int'(duty_h), map_lvl(12));
        measure(-1, 4'd0, hi, lo, sm, dl, sn);
        check("lvl12_high", hi, 2 * map_lvl(12));

        // Drop EN mid-period, reload LEVEL=9, restart
        tick(); tick();
        check("pre_dis_on", int'(pwm_h), 1);
        EN = 1'b0;
        tick();
        check("dis_pwm_h", int'(pwm_h), 0);
        check("dis_pwm_l", int'(pwm_l), 1);
        check("dis_stb", int'(stb_h), 0);
        hi = 0; sm = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            hi += int'(pwm_h);
            sm += int'(stb_h) + int'(stb_l);
        end
        check("dis_idle_high", hi, 0);
        check("dis_idle_stb", sm, 0);
        LEVEL = 4'd9;
        tick();
        check("dis_duty_load", int'(duty_h), map_lvl(9));
        EN = 1'b1;
        wait_stb(64, n, hi, lo);
        check("en_stb_cycles", n, 32);
        check("en_first_high", hi, 2 * map_lvl(9));
        check("en_first_inv_low", lo, 2 * map_lvl(9));
        check("en_duty", int'(duty_h), map_lvl(9));

        // Mapping of LEVEL=8 (gamma or identity) and inverted idle level
        EN = 1'b0;
        LEVEL = 4'd8;
        tick();
`ifdef PWM_GAMMA_EN
        check("map_lvl8", int'(duty_h), 3);
`else
        check("map_lvl8", int'(duty_h), 8);
`endif
        check("idle_inv_level", int'(pwm_l), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
